// File: rtl/maxpool_blk_pkg.sv
// Shared definitions for the conv/pool datapath.
//   DATA_WIDTH_DEF : default signed sample width, matching the conv_blk result width
//   MAX_W          : widest sample the shared compare helper supports
//   smax()         : signed max-of-two over MAX_W bits. Narrower samples are
//                    sign-extended to MAX_W before the call.
package maxpool_blk_pkg;

  localparam int DATA_WIDTH_DEF = 48;
  localparam int MAX_W          = 64;

  function automatic logic signed [MAX_W-1:0] smax(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Combinational signed maximum of two samples.
//   a_i, b_i : signed operands, DATA_WIDTH bits (DATA_WIDTH <= MAX_W)
//   max_o    : the larger of a_i and b_i
module max_cmp
  import maxpool_blk_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] max_o
);

  logic signed [MAX_W-1:0] a_ext;
  logic signed [MAX_W-1:0] b_ext;
  logic                    a_wins;

  // The size cast of a signed operand sign-extends, so the compare is exact.
  assign a_ext  = MAX_W'(a_i);
  assign b_ext  = MAX_W'(b_i);
  // Select the original operand rather than truncating the wide result back down.
  assign a_wins = (smax(a_ext, b_ext) == a_ext);
  assign max_o  = a_wins ? a_i : b_i;

endmodule

// File: rtl/maxpool_blk.sv
// 2x2, stride-2 max pooling over a streamed FM_SIZE x FM_SIZE raster.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   i_en   : i_data valid strobe. The block is always ready and has no backpressure.
//   i_data : signed sample, row-major raster order
//   o_en   : o_data valid, one cycle after the beat that completes a 2x2 window
//   o_data : pooled maximum. It holds its last value while o_en=0.
//   o_done : pulses with the final pooled output of each frame
// Handshake: a beat transfers on every cycle with i_en=1. An output transfers
// on every cycle with o_en=1. Neither side can stall.
module maxpool_blk
  import maxpool_blk_pkg::*;
#(
  parameter int FM_SIZE    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_done
);

  localparam int P_SIZE = FM_SIZE / 2;
  localparam int SPAN   = 2 * P_SIZE;  // rows/cols that take part in pooling
  // One extra bit keeps the counters at least 2 bits wide and lets them hold SPAN.
  localparam int CW     = $clog2(FM_SIZE) + 1;
  localparam int PW     = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  logic signed [DATA_WIDTH-1:0] held_q, held_d;
  logic signed [DATA_WIDTH-1:0] rowbuf_q [P_SIZE];

  logic                         o_en_q, o_en_d;
  logic                         o_done_q, o_done_d;
  logic signed [DATA_WIDTH-1:0] o_data_q, o_data_d;

  logic [PW-1:0]                bidx;
  logic                         in_win;
  logic                         buf_we;
  logic                         emit;
  logic                         last_win;
  logic signed [DATA_WIDTH-1:0] pair_max;
  logic signed [DATA_WIDTH-1:0] quad_max;

  assign bidx   = PW'(col_q >> 1);
  // With an odd FM_SIZE, the last column and the last row fall outside this window.
  assign in_win = (col_q < CW'(SPAN)) && (row_q < CW'(SPAN));

  // Even row: the horizontal pair max is parked in the row buffer.
  // Odd row: it is combined with the parked value to finish the window.
  assign buf_we   = i_en && in_win && !row_q[0] && col_q[0];
  assign emit     = i_en && in_win &&  row_q[0] && col_q[0];
  assign last_win = (row_q == CW'(SPAN - 1)) && (col_q == CW'(SPAN - 1));

  max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_pair (
    .a_i   (held_q),
    .b_i   (i_data),
    .max_o (pair_max)
  );

  max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_quad (
    .a_i   (pair_max),
    .b_i   (rowbuf_q[bidx]),
    .max_o (quad_max)
  );

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    held_d   = held_q;
    o_en_d   = 1'b0;
    o_done_d = 1'b0;
    o_data_d = o_data_q;
    if (i_en) begin
      if (col_q == CW'(FM_SIZE - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(FM_SIZE - 1)) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (in_win && !col_q[0]) begin
        held_d = i_data;
      end
      if (emit) begin
        o_en_d   = 1'b1;
        o_data_d = quad_max;
        o_done_d = last_win;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_q    <= '0;
      row_q    <= '0;
      held_q   <= '0;
      o_en_q   <= 1'b0;
      o_done_q <= 1'b0;
      o_data_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      held_q   <= held_d;
      o_en_q   <= o_en_d;
      o_done_q <= o_done_d;
      o_data_q <= o_data_d;
    end
  end

  // The row buffer has no reset. Every entry is rewritten on the even row
  // before the odd row reads it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && buf_we) begin
      rowbuf_q[bidx] <= pair_max;
    end
  end

  assign o_en   = o_en_q;
  assign o_done = o_done_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_maxpool_blk.sv
module tb_maxpool_blk;

  localparam int DW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en4 = 1'b0;
  logic          en5 = 1'b0;
  logic signed [DW-1:0] d4 = '0;
  logic signed [DW-1:0] d5 = '0;
  logic          oen4, odone4, oen5, odone5;
  logic signed [DW-1:0] odata4, odata5;

  maxpool_blk #(.FM_SIZE(4), .DATA_WIDTH(DW)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en4), .i_data(d4),
    .o_en(oen4), .o_data(odata4), .o_done(odone4)
  );

  maxpool_blk #(.FM_SIZE(5), .DATA_WIDTH(DW)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_en(en5), .i_data(d5),
    .o_en(oen5), .o_data(odata5), .o_done(odone5)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 is the 4x4 instance, index 1 is the 5x5 instance.
  int                   fm [2] = '{4, 5};
  int                   pos_r [2];
  int                   pos_c [2];
  int                   outs_in_frame [2];
  logic signed [DW-1:0] frame [2][5][5];
  logic signed [DW-1:0] last_out [2];
  logic                 exp_en [2];
  logic                 exp_done [2];

  function automatic logic signed [DW-1:0] smax2(input logic signed [DW-1:0] a,
                                                 input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Store the sample at its raster position. If it completes a 2x2 window,
  // predict the window maximum for the next cycle.
  task automatic model_beat(input int k, input logic signed [DW-1:0] v);
    int r, c, p;
    r = pos_r[k];
    c = pos_c[k];
    p = fm[k] / 2;
    frame[k][r][c] = v;
    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * p) && (c < 2 * p)) begin
      last_out[k] = smax2(smax2(frame[k][r-1][c-1], frame[k][r-1][c]),
                          smax2(frame[k][r][c-1],   frame[k][r][c]));
      exp_en[k] = 1'b1;
      outs_in_frame[k]++;
      if (outs_in_frame[k] == p * p) begin
        exp_done[k] = 1'b1;
        outs_in_frame[k] = 0;
      end
    end
    c++;
    if (c == fm[k]) begin
      c = 0;
      r = (r + 1 == fm[k]) ? 0 : r + 1;
    end
    pos_r[k] = r;
    pos_c[k] = c;
  endtask

  task automatic chk_bit(input string name, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", name, obs, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic signed [DW-1:0] obs,
                          input logic signed [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk_bit({tag, "_en4"},     oen4,   exp_en[0]);
    chk_bit({tag, "_done4"},   odone4, exp_done[0]);
    chk_data({tag, "_data4"},  odata4, last_out[0]);
    chk_bit({tag, "_en5"},     oen5,   exp_en[1]);
    chk_bit({tag, "_done5"},   odone5, exp_done[1]);
    chk_data({tag, "_data5"},  odata5, last_out[1]);
  endtask

  // One clock on instance k. The other instance idles. Outputs are checked #1 after the edge.
  task automatic step(input string tag, input int k, input logic en,
                      input logic signed [DW-1:0] v);
    exp_en   = '{1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0};
    en4 = (k == 0) ? en : 1'b0;
    en5 = (k == 1) ? en : 1'b0;
    if (k == 0) d4 = v; else d5 = v;
    if (en) model_beat(k, v);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // One reset cycle. The enables are left high to show they are ignored.
  task automatic do_reset(input logic en_during);
    rst = 1'b1;
    en4 = en_during;
    en5 = en_during;
    d4  = 48'sd77;
    d5  = 48'sd77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    en4 = 1'b0;
    en5 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pos_r[k] = 0;
      pos_c[k] = 0;
      outs_in_frame[k] = 0;
      last_out[k] = '0;
      exp_en[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
    check_all("reset");
  endtask

  initial begin
    logic signed [DW-1:0] v;
    logic signed [DW-1:0] vmin;
    vmin = '0;
    vmin[DW-1] = 1'b1;

    // Reset state
    do_reset(1'b0);

    // Ramp 0..15 on the 4x4 instance: outputs 5, 7, 13, 15
    for (int i = 0; i < 16; i++) step("ramp", 0, 1'b1, DW'(i));

    // Negative ramp: outputs -1, -3, -9, -11
    for (int i = 0; i < 16; i++) step("neg", 0, 1'b1, DW'(-1 - i));

    // Ramp with i_en low on every third cycle
    begin
      int n = 0;
      int cyc = 0;
      while (n < 16) begin
        if (cyc % 3 == 2) step("gap_idle", 0, 1'b0, DW'(999));
        else begin
          step("gap", 0, 1'b1, DW'(n));
          n++;
        end
        cyc++;
      end
    end

    // Odd size on the 5x5 instance: outputs 6, 8, 16, 18
    for (int i = 0; i < 25; i++) step("odd", 1, 1'b1, DW'(i));

    // Reset mid-frame with i_en held high during reset, then a full frame
    for (int i = 0; i < 7; i++) step("pre_rst", 0, 1'b1, DW'(i));
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) step("post_rst", 0, 1'b1, DW'(i));

    // Back-to-back frames
    for (int i = 0; i < 16; i++) step("b2b_a", 0, 1'b1, DW'(i));
    for (int i = 0; i < 16; i++) step("b2b_b", 0, 1'b1, DW'(100 + i));

    // Extremes: the most negative value everywhere, and the most positive value in one corner
    for (int i = 0; i < 16; i++) step("ext_min", 0, 1'b1, vmin);
    for (int i = 0; i < 16; i++) begin
      v = (i == 15) ? ~vmin : vmin;
      step("ext_max", 0, 1'b1, v);
    end

    // Random full-width samples with random gaps on both sizes
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 2; k++) begin
        int n = 0;
        while (n < fm[k] * fm[k]) begin
          v = DW'({$urandom(), $urandom()});
          if ($urandom_range(0, 3) == 0) step("rnd_idle", k, 1'b0, v);
          else begin
            step("rnd", k, 1'b1, v);
            n++;
          end
        end
      end
    end

    // A partial 5x5 frame abandoned by reset, then a clean random frame
    for (int i = 0; i < 13; i++) step("odd_pre", 1, 1'b1, DW'($urandom_range(0, 1000)));
    do_reset(1'b1);
    for (int i = 0; i < 25; i++) step("odd_post", 1, 1'b1, DW'({$urandom(), $urandom()}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
